// File: rtl/burst_sequencer.sv
// burst_sequencer: emits cfg_bursts bursts of cfg_pulses cycles of gate_en,
// separated by cfg_gap low cycles, then a one-cycle done pulse.
// gate_en is a flop output that feeds a downstream clock-gate enable.
// Configuration is captured at start, so cfg_* changes during a run have no effect.
// Every output is registered: each one is the flopped copy of a value decoded
// from the next state, so no input reaches an output without passing a flop.
module burst_sequencer #(
    parameter int PW = 8,
    parameter int BW = 8,
    parameter int GW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] cfg_pulses,
    input  logic [BW-1:0] cfg_bursts,
    input  logic [GW-1:0] cfg_gap,
    output logic          busy,
    output logic          gate_en,
    output logic [BW-1:0] burst_cnt,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pulses_q, pulses_d;
    logic [BW-1:0] bursts_q, bursts_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [BW-1:0] bleft_q, bleft_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          busy_q, busy_d;
    logic          gate_en_q, gate_en_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          cfg_legal;

    assign cfg_legal = (cfg_pulses != '0) && (cfg_bursts != '0);

    // Next-state and counter logic; abort has priority over every transition.
    always_comb begin
        state_d     = state_q;
        pulses_d    = pulses_q;
        bursts_d    = bursts_q;
        gap_d       = gap_q;
        pcnt_d      = pcnt_q;
        gcnt_d      = gcnt_q;
        bleft_d     = bleft_q;
        burst_cnt_d = burst_cnt_q;
        err_d       = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            pulses_d    = cfg_pulses;
                            bursts_d    = cfg_bursts;
                            gap_d       = cfg_gap;
                            pcnt_d      = cfg_pulses - PW'(1);
                            bleft_d     = cfg_bursts;
                            burst_cnt_d = '0;
                            state_d     = S_BURST;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - PW'(1);
                    end else begin
                        // Last enable cycle of this burst.
                        if (burst_cnt_q != '1) begin
                            burst_cnt_d = burst_cnt_q + BW'(1);
                        end
                        bleft_d = bleft_q - BW'(1);
                        if (bleft_q == BW'(1)) begin
                            state_d = S_DONE;
                        end else if (gap_q == '0) begin
                            // Back-to-back: stay in BURST so gate_en never drops.
                            pcnt_d = pulses_q - PW'(1);
                        end else begin
                            gcnt_d  = gap_q - GW'(1);
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt_q != '0) begin
                        gcnt_d = gcnt_q - GW'(1);
                    end else begin
                        pcnt_d  = pulses_q - PW'(1);
                        state_d = S_BURST;
                    end
                end
                S_DONE: begin
                    // A start seen here is deliberately dropped.
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs decoded from the next state so they flop alongside it.
        gate_en_d = (state_d == S_BURST);
        busy_d    = (state_d == S_BURST) || (state_d == S_GAP);
        done_d    = (state_d == S_DONE);
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pulses_q    <= '0;
            bursts_q    <= '0;
            gap_q       <= '0;
            pcnt_q      <= '0;
            gcnt_q      <= '0;
            bleft_q     <= '0;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
            gate_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulses_q    <= pulses_d;
            bursts_q    <= bursts_d;
            gap_q       <= gap_d;
            pcnt_q      <= pcnt_d;
            gcnt_q      <= gcnt_d;
            bleft_q     <= bleft_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
            gate_en_q   <= gate_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign gate_en   = gate_en_q;
    assign burst_cnt = burst_cnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed testbench for burst_sequencer. Inputs change on the falling edge,
// and outputs are sampled on the falling edge, half a cycle after each
// rising edge. Trace index i=0 is the first cycle after the edge that
// sampled start.
module tb_burst_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_pulses;
    logic [7:0]  cfg_bursts;
    logic [15:0] cfg_gap;
    logic        busy;
    logic        gate_en;
    logic [7:0]  burst_cnt;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;

    logic [31:0] g_v, d_v, b_v, e_v;

    burst_sequencer #(.PW(8), .BW(8), .GW(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cfg_pulses (cfg_pulses),
        .cfg_bursts (cfg_bursts),
        .cfg_gap    (cfg_gap),
        .busy       (busy),
        .gate_en    (gate_en),
        .burst_cnt  (burst_cnt),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture a trace of n cycles starting now; abort is raised after cycle abort_at.
    task automatic capture(input int n, input int abort_at);
        g_v = '0; d_v = '0; b_v = '0; e_v = '0;
        for (int i = 0; i < n; i++) begin
            g_v[i] = gate_en;
            d_v[i] = done;
            b_v[i] = busy;
            e_v[i] = err;
            abort = (i == abort_at);
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic launch(input logic [7:0] p, input logic [7:0] b, input logic [15:0] g);
        cfg_pulses = p; cfg_bursts = b; cfg_gap = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_pulses = '0; cfg_bursts = '0; cfg_gap = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, gate_en, done, err, burst_cnt, dbg_state} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, gate_en, done, err, burst_cnt, dbg_state});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_burst;
        launch(8'd4, 8'd1, 16'd0);
        capture(6, -1);
        tests_run++;
        if (g_v[5:0] !== 6'b001111) begin
            tests_failed++; $display("FAIL single_gate got=%b exp=001111", g_v[5:0]);
        end
        tests_run++;
        if (d_v[5:0] !== 6'b010000) begin
            tests_failed++; $display("FAIL single_done got=%b exp=010000", d_v[5:0]);
        end
        tests_run++;
        if (b_v[5:0] !== 6'b001111) begin
            tests_failed++; $display("FAIL single_busy got=%b exp=001111", b_v[5:0]);
        end
        tests_run++;
        if (burst_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL single_burst_cnt got=%0d exp=1", burst_cnt);
        end
    endtask

    task automatic test_gapped;
        launch(8'd3, 8'd3, 16'd2);
        capture(16, -1);
        tests_run++;
        if (g_v[15:0] !== 16'b0001110011100111) begin
            tests_failed++; $display("FAIL gapped_gate got=%b exp=0001110011100111", g_v[15:0]);
        end
        tests_run++;
        if (d_v[15:0] !== 16'b0010000000000000) begin
            tests_failed++; $display("FAIL gapped_done got=%b exp=0010000000000000", d_v[15:0]);
        end
        tests_run++;
        if (b_v[15:0] !== 16'b0001111111111111) begin
            tests_failed++; $display("FAIL gapped_busy got=%b exp=0001111111111111", b_v[15:0]);
        end
        tests_run++;
        if (burst_cnt !== 8'd3) begin
            tests_failed++; $display("FAIL gapped_burst_cnt got=%0d exp=3", burst_cnt);
        end
    endtask

    // gap=0 bursts merge; cfg changes and start pulses mid-run must not matter.
    task automatic test_back_to_back;
        launch(8'd2, 8'd4, 16'd0);
        cfg_pulses = 8'd7; cfg_bursts = 8'd9; cfg_gap = 16'd3;
        g_v = '0; d_v = '0; e_v = '0;
        for (int i = 0; i < 10; i++) begin
            g_v[i] = gate_en;
            d_v[i] = done;
            e_v[i] = err;
            start = (i == 2) || (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (g_v[9:0] !== 10'b0011111111) begin
            tests_failed++; $display("FAIL b2b_gate got=%b exp=0011111111", g_v[9:0]);
        end
        tests_run++;
        if (d_v[9:0] !== 10'b0100000000) begin
            tests_failed++; $display("FAIL b2b_done got=%b exp=0100000000", d_v[9:0]);
        end
        tests_run++;
        if (e_v[9:0] !== 10'b0) begin
            tests_failed++; $display("FAIL b2b_busy_start_err got=%b exp=0", e_v[9:0]);
        end
        tests_run++;
        if (burst_cnt !== 8'd4) begin
            tests_failed++; $display("FAIL b2b_burst_cnt got=%0d exp=4", burst_cnt);
        end
    endtask

    // start held high: the DONE-cycle start is dropped, next run begins from IDLE.
    task automatic test_start_in_done;
        cfg_pulses = 8'd1; cfg_bursts = 8'd1; cfg_gap = 16'd0;
        start = 1'b1;
        @(negedge clk);
        g_v = '0; d_v = '0;
        for (int i = 0; i < 7; i++) begin
            g_v[i] = gate_en;
            d_v[i] = done;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (g_v[6:0] !== 7'b1001001) begin
            tests_failed++; $display("FAIL done_start_gate got=%b exp=1001001", g_v[6:0]);
        end
        tests_run++;
        if (d_v[6:0] !== 7'b0010010) begin
            tests_failed++; $display("FAIL done_start_done got=%b exp=0010010", d_v[6:0]);
        end
    endtask

    task automatic test_illegal_cfg;
        launch(8'd0, 8'd3, 16'd1);
        capture(4, -1);
        tests_run++;
        if (e_v[3:0] !== 4'b0001) begin
            tests_failed++; $display("FAIL illegal_pulses_err got=%b exp=0001", e_v[3:0]);
        end
        tests_run++;
        if ((g_v[3:0] | b_v[3:0] | d_v[3:0]) !== 4'b0) begin
            tests_failed++; $display("FAIL illegal_pulses_outs got=%b/%b/%b exp=0", g_v[3:0], b_v[3:0], d_v[3:0]);
        end
        launch(8'd3, 8'd0, 16'd1);
        capture(4, -1);
        tests_run++;
        if (e_v[3:0] !== 4'b0001) begin
            tests_failed++; $display("FAIL illegal_bursts_err got=%b exp=0001", e_v[3:0]);
        end
        tests_run++;
        if ((g_v[3:0] | b_v[3:0] | d_v[3:0]) !== 4'b0) begin
            tests_failed++; $display("FAIL illegal_bursts_outs got=%b/%b/%b exp=0", g_v[3:0], b_v[3:0], d_v[3:0]);
        end
    endtask

    task automatic test_abort;
        launch(8'd5, 8'd3, 16'd4);
        capture(20, 11);
        tests_run++;
        if (g_v[19:0] !== 20'b00000000111000011111) begin
            tests_failed++; $display("FAIL abort_gate got=%b exp=00000000111000011111", g_v[19:0]);
        end
        tests_run++;
        if (b_v[19:0] !== 20'b00000000111111111111) begin
            tests_failed++; $display("FAIL abort_busy got=%b exp=00000000111111111111", b_v[19:0]);
        end
        tests_run++;
        if (d_v[19:0] !== 20'b0) begin
            tests_failed++; $display("FAIL abort_done got=%b exp=0", d_v[19:0]);
        end
        tests_run++;
        if (burst_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL abort_burst_cnt got=%0d exp=1", burst_cnt);
        end
        cfg_pulses = 8'd2; cfg_bursts = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if ({busy, gate_en, err, dbg_state} !== 5'b0) begin
            tests_failed++; $display("FAIL abort_start_same got=%b exp=00000", {busy, gate_en, err, dbg_state});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset_and_max;
        int g_cnt, gap_cnt, done_cnt;
        bit seen;
        launch(8'd6, 8'd2, 16'd0);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, gate_en, done, err, burst_cnt, dbg_state} !== 14'd0) begin
            tests_failed++; $display("FAIL async_reset got=%h exp=0", {busy, gate_en, done, err, burst_cnt, dbg_state});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        launch(8'd255, 8'd2, 16'd65535);
        g_cnt = 0; gap_cnt = 0; done_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 70000 && !seen; c++) begin
            if (gate_en) g_cnt++;
            if (busy && !gate_en) gap_cnt++;
            if (done) begin done_cnt++; seen = 1'b1; end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL max_timeout got=no_done exp=done");
        end
        tests_run++;
        if (g_cnt !== 510) begin
            tests_failed++; $display("FAIL max_gate_cycles got=%0d exp=510", g_cnt);
        end
        tests_run++;
        if (gap_cnt !== 65535) begin
            tests_failed++; $display("FAIL max_gap_cycles got=%0d exp=65535", gap_cnt);
        end
        tests_run++;
        if (burst_cnt !== 8'd2) begin
            tests_failed++; $display("FAIL max_burst_cnt got=%0d exp=2", burst_cnt);
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy} !== 2'b00) begin
            tests_failed++; $display("FAIL max_done_pulse got=%b exp=00", {done, busy});
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_burst();
        test_gapped();
        test_back_to_back();
        test_start_in_done();
        test_illegal_cfg();
        test_abort();
        test_async_reset_and_max();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
